// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, bit-counter width, mode decode helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Mode decode is shared with the SPI master so both ends agree on which
// SCLK edge samples and which one shifts.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

  // Clock polarity: idle level of SCLK.
  function automatic logic f_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
  function automatic logic f_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

  // 1 = data is sampled on the rising SCLK edge (shift on falling),
  // 0 = sampled on falling (shift on rising).
  function automatic logic f_sample_rise(input logic [1:0] mode);
    return ~(f_cpol(mode) ^ f_cpha(mode));
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI target bundle: serial pins plus the byte-wide parallel TX/RX side.
// Latency: n/a (wiring only).
// Backpressure: TX side is a ready/strobe pair; RX side is a strobe with no stall.
// Ports (slave view):
//   in : i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_DV, i_TX_Byte[7:0]
//   out: o_SPI_MISO, o_SPI_MISO_OE, o_TX_Ready, o_RX_DV, o_RX_Byte[7:0], o_CS_Active
interface spi_slave_if;
  import spi_pkg::*;

  logic                  i_SPI_Clk;
  logic                  i_SPI_CS_n;
  logic                  i_SPI_MOSI;
  logic                  o_SPI_MISO;
  logic                  o_SPI_MISO_OE;
  logic                  i_TX_DV;
  logic [SPI_BYTE_W-1:0] i_TX_Byte;
  logic                  o_TX_Ready;
  logic                  o_RX_DV;
  logic [SPI_BYTE_W-1:0] o_RX_Byte;
  logic                  o_CS_Active;

  modport slave (
    input  i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_DV, i_TX_Byte,
    output o_SPI_MISO, o_SPI_MISO_OE, o_TX_Ready, o_RX_DV, o_RX_Byte, o_CS_Active
  );

  modport master (
    output i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_DV, i_TX_Byte,
    input  o_SPI_MISO, o_SPI_MISO_OE, o_TX_Ready, o_RX_DV, o_RX_Byte, o_CS_Active
  );

endinterface

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer for an asynchronous pin plus rise/fall pulse detection.
// Latency: a pin change shows as a one-cycle edge pulse after 2 i_Clk edges,
//          so logic registering on it acts on the 3rd edge. Backpressure: none.
// Ports: i_Clk, i_Rst_L (async, active low), i_async (raw pin),
//        o_rise / o_fall (one-cycle pulses in the i_Clk domain).
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0   // idle level of the pin, avoids a spurious edge out of reset
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_dly  <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_rise =  r_sync & ~r_dly;
  assign o_fall = ~r_sync &  r_dly;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled SCLK/CS_n/MOSI, full-duplex MSB-first byte shifter.
// Latency: pin event acted on 3 i_Clk later; o_RX_DV one cycle after the 8th sample edge.
// Backpressure: none on the SPI side; i_TX_DV is dropped while o_TX_Ready=0,
//               and IDLE_BYTE is sent when no TX byte is pending at a byte start.
// Ports: i_Clk (>= 8x SCLK), i_Rst_L (async, active low), bus (spi_slave_if.slave).
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SPI_MODE  = 0,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = 8'hFF
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  spi_slave_if.slave  bus
);

  localparam logic [1:0]           LP_MODE        = 2'(SPI_MODE);
  localparam logic                 LP_SAMPLE_RISE = f_sample_rise(LP_MODE);
  localparam logic [SPI_CNT_W-1:0] LP_LAST_BIT    = SPI_CNT_W'(SPI_BYTE_W - 1);

  // ---------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_n_rise;
  logic w_cs_n_fall;

  spi_sync_edge #(.RST_VAL(f_cpol(LP_MODE))) u_sync_sclk (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_async (bus.i_SPI_Clk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs_n (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_async (bus.i_SPI_CS_n),
    .o_rise  (w_cs_n_rise),
    .o_fall  (w_cs_n_fall)
  );

  // MOSI is only ever read on an SCLK edge pulse; its second stage lines up
  // with the SCLK stage that produced that pulse.
  logic r_mosi_meta;
  logic r_mosi_sync;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= bus.i_SPI_MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Shift / count control
  // ---------------------------------------------------------------------
  logic                  r_cs_active;
  logic [SPI_CNT_W-1:0]  r_bit_cnt;
  logic [SPI_BYTE_W-2:0] r_rx_shift;
  logic [SPI_BYTE_W-1:0] r_rx_byte;
  logic                  r_rx_dv;
  logic [SPI_BYTE_W-1:0] r_tx_shift;
  logic [SPI_BYTE_W-1:0] r_tx_hold;
  logic                  r_tx_full;

  logic w_cs_assert;
  logic w_cs_deassert;
  logic w_sample;
  logic w_shift;
  logic w_byte_done;
  logic w_byte_start;
  logic w_tx_accept;

  assign w_cs_assert   = w_cs_n_fall;
  assign w_cs_deassert = w_cs_n_rise;

  // SCLK edges only count while CS is active and not being released now.
  assign w_sample = r_cs_active & ~w_cs_deassert &
                    (LP_SAMPLE_RISE ? w_sclk_rise : w_sclk_fall);

  // A shift edge seen at bit 0 is either the CPHA=1 "present MSB" edge (the MSB
  // is already on MISO from the byte-start load) or the CPHA=0 trailing edge
  // after the 8th sample (the next byte's MSB must stay put). Both are no-ops.
  assign w_shift = r_cs_active & ~w_cs_deassert & (r_bit_cnt != '0) &
                   (LP_SAMPLE_RISE ? w_sclk_fall : w_sclk_rise);

  assign w_byte_done  = w_sample & (r_bit_cnt == LP_LAST_BIT);
  assign w_byte_start = w_cs_assert | w_byte_done;
  assign w_tx_accept  = bus.i_TX_DV & ~r_tx_full;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cs_active <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_byte   <= '0;
      r_rx_dv     <= 1'b0;
    end else begin
      if (w_cs_assert) begin
        r_cs_active <= 1'b1;
      end else if (w_cs_deassert) begin
        r_cs_active <= 1'b0;
      end

      // Counter wraps 7->0 on its own, which doubles as the next byte start.
      // A CS change abandons any partial byte.
      if (w_cs_assert || w_cs_deassert) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_bit_cnt <= r_bit_cnt + SPI_CNT_W'(1);
      end

      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[SPI_BYTE_W-3:0], r_mosi_sync};
      end

      r_rx_dv <= w_byte_done;
      if (w_byte_done) begin
        r_rx_byte <= {r_rx_shift, r_mosi_sync};
      end
    end
  end

  // TX path. On a byte-start load the buffer's old state wins; a strobe in the
  // same cycle can only be accepted if the buffer was already empty, so it is
  // kept for the following byte.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_shift <= '0;
      r_tx_hold  <= '0;
      r_tx_full  <= 1'b0;
    end else begin
      if (w_byte_start) begin
        r_tx_shift <= r_tx_full ? r_tx_hold : IDLE_BYTE;
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
      end

      if (w_tx_accept) begin
        r_tx_hold <= bus.i_TX_Byte;
      end

      if (w_byte_start && r_tx_full) begin
        r_tx_full <= 1'b0;
      end else if (w_tx_accept) begin
        r_tx_full <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (all derived from async-reset flops, so reset is immediate)
  // ---------------------------------------------------------------------
  assign bus.o_SPI_MISO    = r_cs_active & r_tx_shift[SPI_BYTE_W-1];
  assign bus.o_SPI_MISO_OE = r_cs_active;
  assign bus.o_CS_Active   = r_cs_active;
  assign bus.o_TX_Ready    = ~r_tx_full;
  assign bus.o_RX_DV       = r_rx_dv;
  assign bus.o_RX_Byte     = r_rx_byte;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode on a shared clock/reset,
// driven by a behavioural SPI master; received bytes checked via a scoreboard.
`timescale 1ns/1ps
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HALF = 80;   // SCLK half period: i_Clk = 16x SCLK

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       r_sclk [4];
  logic       r_cs_n [4];
  logic       r_tx_dv[4];
  logic       r_mosi;
  logic [7:0] r_tx_byte;

  logic       w_miso    [4];
  logic       w_oe      [4];
  logic       w_ready   [4];
  logic       w_rx_dv   [4];
  logic       w_cs_act  [4];
  logic [7:0] w_rx_byte [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_if u_if();
    assign u_if.i_SPI_Clk  = r_sclk[g];
    assign u_if.i_SPI_CS_n = r_cs_n[g];
    assign u_if.i_SPI_MOSI = r_mosi;
    assign u_if.i_TX_DV    = r_tx_dv[g];
    assign u_if.i_TX_Byte  = r_tx_byte;
    assign w_miso[g]       = u_if.o_SPI_MISO;
    assign w_oe[g]         = u_if.o_SPI_MISO_OE;
    assign w_ready[g]      = u_if.o_TX_Ready;
    assign w_rx_dv[g]      = u_if.o_RX_DV;
    assign w_cs_act[g]     = u_if.o_CS_Active;
    assign w_rx_byte[g]    = u_if.o_RX_Byte;

    spi_slave #(.SPI_MODE(g), .IDLE_BYTE(8'hFF)) u_dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .bus     (u_if.slave)
    );
  end

  // ------------------------------------------------------------------
  // Checking infrastructure
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   dv_cnt   = 0;
  int   cur_m    = 0;
  logic ready_low_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed byte the master sends is queued; each RX_DV
  // pops one entry and must match both the instance and the data.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int m = 0; m < 4; m++) begin
        if (w_rx_dv[m]) begin
          dv_cnt++;
          if (q_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_dv_unexpected: mode %0d byte %0h with empty queue", m, w_rx_byte[m]);
          end else begin
            e = q_exp.pop_front();
            chk("sb_rx_mode", 32'(m), 32'(e.mode));
            chk("sb_rx_byte", 32'(w_rx_byte[m]), 32'(e.data));
          end
        end
      end
      if (!w_ready[cur_m]) ready_low_seen = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic tx_load(input int m, input logic [7:0] b);
    @(negedge clk);
    r_tx_dv[m] = 1'b1;
    r_tx_byte  = b;
    @(negedge clk);
    r_tx_dv[m] = 1'b0;
  endtask

  task automatic cs_set(input int m, input logic v);
    @(negedge clk);
    r_cs_n[m] = v;
    repeat (6) @(negedge clk);
  endtask

  // Behavioural master: nbits clock periods, MSB first, captures MISO on the
  // sample edge. Only complete bytes are queued for the scoreboard.
  task automatic spi_bits(input int m, input logic [7:0] b, input int nbits,
                          output logic [7:0] miso);
    bit cpol;
    bit cpha;
    cpol = m[1];
    cpha = m[0];
    miso = 8'h00;
    if (nbits == 8) q_exp.push_back(exp_t'{mode: 2'(m), data: b});
    if (!cpha) r_mosi = b[7];
    for (int i = 0; i < nbits; i++) begin
      #HALF;
      r_sclk[m] = ~cpol;
      if (cpha) r_mosi = b[7-i];
      else      miso[7-i] = w_miso[m];
      #HALF;
      r_sclk[m] = cpol;
      if (cpha)        miso[7-i] = w_miso[m];
      else if (i < 7)  r_mosi = b[6-i];
    end
    #HALF;
  endtask

  // ------------------------------------------------------------------
  // Table-driven single-byte transfers
  // ------------------------------------------------------------------
  typedef struct {
    int         mode;
    bit         pre_vld;   // preload the TX buffer before CS
    logic [7:0] pre;
    bit         poke;      // strobe 8'h77 while the buffer is full
    logic [7:0] mosi;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] mb0, mb1, mb2, dummy;
    int t;

    for (int m = 0; m < 4; m++) begin
      r_sclk[m]  = m[1];
      r_cs_n[m]  = 1'b1;
      r_tx_dv[m] = 1'b0;
    end
    r_mosi    = 1'b0;
    r_tx_byte = 8'h00;

    vecs[0] = '{0, 1'b1, 8'h3C, 1'b0, 8'hA5, 8'h3C};
    vecs[1] = '{0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF};
    vecs[2] = '{0, 1'b1, 8'hC3, 1'b1, 8'hC3, 8'hC3};
    vecs[3] = '{1, 1'b1, 8'hC3, 1'b1, 8'hC3, 8'hC3};
    vecs[4] = '{2, 1'b1, 8'hC3, 1'b1, 8'hC3, 8'hC3};
    vecs[5] = '{3, 1'b1, 8'hC3, 1'b1, 8'hC3, 8'hC3};

    // Reset state
    repeat (4) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk("rst_miso",    32'(w_miso[m]),    0);
      chk("rst_oe",      32'(w_oe[m]),      0);
      chk("rst_ready",   32'(w_ready[m]),   1);
      chk("rst_rx_dv",   32'(w_rx_dv[m]),   0);
      chk("rst_rx_byte", 32'(w_rx_byte[m]), 0);
      chk("rst_cs_act",  32'(w_cs_act[m]),  0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      cur_m  = vecs[v].mode;
      dv_cnt = 0;
      ready_low_seen = 1'b0;
      if (vecs[v].pre_vld) begin
        tx_load(cur_m, vecs[v].pre);
        chk("vec_ready_after_load", 32'(w_ready[cur_m]), 0);
      end
      if (vecs[v].poke) begin
        tx_load(cur_m, 8'h77);
        chk("vec_ready_after_poke", 32'(w_ready[cur_m]), 0);
      end
      cs_set(cur_m, 1'b0);
      chk("vec_cs_active", 32'(w_cs_act[cur_m]), 1);
      chk("vec_miso_oe",   32'(w_oe[cur_m]),     1);
      ready_low_seen = 1'b0;
      spi_bits(cur_m, vecs[v].mosi, 8, mb0);
      cs_set(cur_m, 1'b1);
      chk("vec_miso_byte",   32'(mb0),               32'(vecs[v].exp_miso));
      chk("vec_rx_byte",     32'(w_rx_byte[cur_m]),  32'(vecs[v].mosi));
      chk("vec_rx_dv_count", 32'(dv_cnt),            1);
      chk("vec_ready_low",   32'(ready_low_seen),    0);
      chk("vec_oe_idle",     32'(w_oe[cur_m]),       0);
      chk("vec_miso_idle",   32'(w_miso[cur_m]),     0);
    end

    // Three bytes under one CS, buffer refilled as it drains
    cur_m  = 0;
    dv_cnt = 0;
    tx_load(0, 8'hAA);
    cs_set(0, 1'b0);
    fork
      begin
        spi_bits(0, 8'h01, 8, mb0);
        spi_bits(0, 8'h02, 8, mb1);
        spi_bits(0, 8'h03, 8, mb2);
      end
      begin : refill
        int tw;
        tw = 0;
        while (!w_ready[0] && tw < 200) begin @(negedge clk); tw++; end
        chk("multi_ready_wait", 32'(tw < 200), 1);
        tx_load(0, 8'h11);
        tw = 0;
        while (!w_rx_dv[0] && tw < 4000) begin @(negedge clk); tw++; end
        chk("multi_rx_dv_wait", 32'(tw < 4000), 1);
        tx_load(0, 8'h22);
      end
    join
    cs_set(0, 1'b1);
    chk("multi_miso0", 32'(mb0), 32'h AA);
    chk("multi_miso1", 32'(mb1), 32'h 11);
    chk("multi_miso2", 32'(mb2), 32'h 22);
    chk("multi_dv_cnt", 32'(dv_cnt), 3);

    // CS released after 5 bits: no RX, buffer preserved
    dv_cnt = 0;
    cs_set(0, 1'b0);
    tx_load(0, 8'h96);
    chk("abort_ready_full", 32'(w_ready[0]), 0);
    spi_bits(0, 8'hB0, 5, dummy);
    cs_set(0, 1'b1);
    chk("abort_dv_cnt",   32'(dv_cnt),       0);
    chk("abort_rx_byte",  32'(w_rx_byte[0]), 32'h03);
    chk("abort_ready",    32'(w_ready[0]),   0);
    cs_set(0, 1'b0);
    spi_bits(0, 8'h5A, 8, mb0);
    cs_set(0, 1'b1);
    chk("abort_next_miso", 32'(mb0),          32'h96);
    chk("abort_next_rx",   32'(w_rx_byte[0]), 32'h5A);
    chk("abort_next_dv",   32'(dv_cnt),       1);

    // Asynchronous reset mid-byte
    cs_set(0, 1'b0);
    tx_load(0, 8'h4E);
    spi_bits(0, 8'hE7, 3, dummy);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_miso",    32'(w_miso[0]),    0);
    chk("arst_oe",      32'(w_oe[0]),      0);
    chk("arst_ready",   32'(w_ready[0]),   1);
    chk("arst_rx_dv",   32'(w_rx_dv[0]),   0);
    chk("arst_rx_byte", 32'(w_rx_byte[0]), 0);
    chk("arst_cs_act",  32'(w_cs_act[0]),  0);
    chk("arst_rx_byte_m3", 32'(w_rx_byte[3]), 0);
    r_cs_n[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    dv_cnt = 0;
    tx_load(0, 8'h81);
    cs_set(0, 1'b0);
    spi_bits(0, 8'h3C, 8, mb0);
    cs_set(0, 1'b1);
    chk("post_rst_miso", 32'(mb0),          32'h81);
    chk("post_rst_rx",   32'(w_rx_byte[0]), 32'h3C);
    chk("post_rst_dv",   32'(dv_cnt),       1);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(q_exp.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
